// File: rtl/capture_pkg.sv
// Shared definitions for the input-capture timer: register map, control/status
// bit positions and the measurement state encoding.
package capture_pkg;

  localparam logic [2:0] REG_COUNT  = 3'd0;
  localparam logic [2:0] REG_CTRL   = 3'd1;
  localparam logic [2:0] REG_PSC    = 3'd2;
  localparam logic [2:0] REG_PERIOD = 3'd3;
  localparam logic [2:0] REG_HIGH   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [2:0] REG_FILTER = 3'd6;

  localparam int unsigned CTRL_ENABLE  = 0;
  localparam int unsigned CTRL_ONESHOT = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;

  localparam int unsigned STAT_VALID   = 0;
  localparam int unsigned STAT_OVERRUN = 1;
  localparam int unsigned STAT_TIMEOUT = 2;

  localparam logic [31:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    HIGH_PH,
    LOW_PH
  } capture_state_t;

endpackage

// File: rtl/capture_filter.sv
// Two-flop synchronizer, N-sample glitch filter and edge detector for the
// capture pin. Every change of the filtered level needs len+1 differing samples.
module capture_filter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       din,
  input  logic [3:0] len,
  output logic       level,
  output logic       rise,
  output logic       fall
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_level;
  logic       r_level_d;
  logic [3:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else if (en) begin
      r_sync1   <= din;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // A sample matching the current level restarts the run; len = 0 passes straight through.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt >= len) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_level & ~r_level_d;
  assign fall  = ~r_level & r_level_d;

endmodule

// File: rtl/input_capture.sv
// Memory-mapped input-capture timer: measures period and high time of an
// external pulse train in prescaled ticks and raises a level IRQ per capture.
module input_capture
  import capture_pkg::*;
#(
  parameter logic [31:0] PRESCALER_DEFAULT_VALUE = '0,
  parameter logic [31:0] FILTER_DEFAULT_VALUE    = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        chipSelect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  addr,
  input  logic [31:0] writeData,
  input  logic        capture_in,
  output logic [31:0] readData,
  output logic        irq
);

  capture_state_t r_state, w_state_nxt;

  logic [2:0]  r_ctrl;
  logic [31:0] r_psc;
  logic [3:0]  r_filter;
  logic [31:0] r_period;
  logic [31:0] r_high;
  logic [2:0]  r_status;
  logic [31:0] r_count;
  logic [31:0] r_psc_cnt;
  logic [31:0] r_rdata;

  logic        w_rise, w_fall;
  logic        w_bus_wr, w_bus_rd;
  logic        w_wr_ctrl, w_wr_psc, w_wr_status, w_wr_filter;
  logic        w_tick, w_tmo;
  logic [2:0]  w_ctrl_wd;
  logic        w_en_eff;
  logic [31:0] w_count_inc;
  logic [31:0] w_count_nxt, w_period_nxt, w_high_nxt;
  logic [2:0]  w_status_set;
  logic        w_psc_restart;
  logic        w_oneshot_clr;
  logic [31:0] w_rmux;

  capture_filter u_filter (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .din   (capture_in),
    .len   (r_filter),
    .level (),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  assign w_bus_wr    = chipSelect & write & en;
  assign w_bus_rd    = chipSelect & read & ~write & en;
  assign w_wr_ctrl   = w_bus_wr & (addr == REG_CTRL);
  assign w_wr_psc    = w_bus_wr & (addr == REG_PSC);
  assign w_wr_status = w_bus_wr & (addr == REG_STATUS);
  assign w_wr_filter = w_bus_wr & (addr == REG_FILTER);

  assign w_tick      = (r_psc_cnt == r_psc);
  assign w_tmo       = (r_count == COUNT_MAX) & w_tick;
  assign w_count_inc = r_count + 32'(w_tick);
  assign w_ctrl_wd   = w_wr_ctrl ? writeData[2:0] : r_ctrl;
  // Disabling by bus write takes effect on the write edge itself, so nothing is captured afterwards.
  assign w_en_eff    = w_ctrl_wd[CTRL_ENABLE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (en) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_period_nxt  = r_period;
    w_high_nxt    = r_high;
    w_status_set  = '0;
    w_psc_restart = 1'b0;
    w_oneshot_clr = 1'b0;
    if (!w_en_eff) begin
      w_state_nxt = IDLE;
      w_count_nxt = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_count_nxt = '0;
          w_state_nxt = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (w_rise) begin
            w_count_nxt   = '0;
            w_psc_restart = 1'b1;
            w_state_nxt   = HIGH_PH;
          end
        end
        HIGH_PH: begin
          if (w_tmo) begin
            w_status_set[STAT_TIMEOUT] = 1'b1;
            w_count_nxt = '0;
            w_state_nxt = WAIT_RISE;
          end else begin
            w_count_nxt = w_count_inc;
            if (w_fall) begin
              w_high_nxt  = w_count_inc;
              w_state_nxt = LOW_PH;
            end
          end
        end
        LOW_PH: begin
          if (w_tmo) begin
            w_status_set[STAT_TIMEOUT] = 1'b1;
            w_count_nxt = '0;
            w_state_nxt = WAIT_RISE;
          end else if (w_rise) begin
            w_period_nxt                = w_count_inc;
            w_status_set[STAT_VALID]    = 1'b1;
            w_status_set[STAT_OVERRUN]  = r_status[STAT_VALID];
            w_count_nxt                 = '0;
            w_psc_restart               = 1'b1;
            if (r_ctrl[CTRL_ONESHOT]) begin
              w_oneshot_clr = 1'b1;
              w_state_nxt   = IDLE;
            end else begin
              w_state_nxt = HIGH_PH;
            end
          end else begin
            w_count_nxt = w_count_inc;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_rmux = '0;
    case (addr)
      REG_COUNT:  w_rmux = r_count;
      REG_CTRL:   w_rmux = {29'd0, r_ctrl};
      REG_PSC:    w_rmux = r_psc;
      REG_PERIOD: w_rmux = r_period;
      REG_HIGH:   w_rmux = r_high;
      REG_STATUS: w_rmux = {29'd0, r_status};
      REG_FILTER: w_rmux = {28'd0, r_filter};
      default:    w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl    <= '0;
      r_psc     <= PRESCALER_DEFAULT_VALUE;
      r_filter  <= FILTER_DEFAULT_VALUE[3:0];
      r_period  <= '0;
      r_high    <= '0;
      r_status  <= '0;
      r_count   <= '0;
      r_psc_cnt <= '0;
      r_rdata   <= '0;
    end else if (en) begin
      r_ctrl    <= w_oneshot_clr ? (w_ctrl_wd & ~3'b001) : w_ctrl_wd;
      // Hardware set is OR-ed after the W1C mask so it wins a same-cycle clear.
      r_status  <= (r_status & ~(w_wr_status ? writeData[2:0] : 3'b000)) | w_status_set;
      r_period  <= w_period_nxt;
      r_high    <= w_high_nxt;
      r_count   <= w_count_nxt;
      r_psc_cnt <= (w_psc_restart || w_tick) ? '0 : r_psc_cnt + 32'd1;
      if (w_wr_psc)    r_psc    <= writeData;
      if (w_wr_filter) r_filter <= writeData[3:0];
      if (w_bus_rd)    r_rdata  <= w_rmux;
    end
  end

  assign readData = r_rdata;
  assign irq      = r_status[STAT_VALID] & r_ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_input_capture.sv
// Scoreboard bench for input_capture: reads push expected values, a monitor
// pops and compares one cycle later when read data becomes valid.
module tb_input_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        chipSelect;
  logic        write;
  logic        read;
  logic [2:0]  addr;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        capture_in;
  logic        irq;

  always #5 clk = ~clk;

  input_capture #(
    .PRESCALER_DEFAULT_VALUE (32'd3),
    .FILTER_DEFAULT_VALUE    (32'd2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .chipSelect (chipSelect),
    .write      (write),
    .read       (read),
    .addr       (addr),
    .writeData  (writeData),
    .capture_in (capture_in),
    .readData   (readData),
    .irq        (irq)
  );

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  chk_t        rd_q[$];
  chk_t        imm_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc      = 0;
  bit          done     = 1'b0;
  logic        rd_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) rd_pend <= 1'b0;
    else     rd_pend <= chipSelect & read & ~write & en;
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    chk_t c;
    cyc++;
    while (imm_q.size() > 0) begin
      c = imm_q.pop_front();
      compare(c.name, c.act, c.exp);
    end
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", readData);
      end else begin
        c = rd_q.pop_front();
        compare(c.name, readData, c.exp);
      end
    end
    if (done || cyc > 80000) begin
      if (!done) begin
        n_checks++;
        n_errors++;
        $display("FAIL sim_timeout: got %0d cycles expected completion", cyc);
      end
      if (rd_q.size() != 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pending_reads: got %0d outstanding expected 0", rd_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipSelect = 1'b1; write = 1'b1; addr = a; writeData = d;
    @(negedge clk);
    chipSelect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    chk_t c;
    @(negedge clk);
    chipSelect = 1'b1; read = 1'b1; addr = a;
    c.name = n; c.act = 'x; c.exp = e;
    rd_q.push_back(c);
    @(negedge clk);
    chipSelect = 1'b0; read = 1'b0;
  endtask

  task automatic expect_now(input string n, input logic [31:0] act, input logic [31:0] e);
    chk_t c;
    c.name = n; c.act = act; c.exp = e;
    imm_q.push_back(c);
  endtask

  task automatic drive(input logic v, input int unsigned n);
    @(negedge clk);
    capture_in = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic period(input int unsigned h, input int unsigned l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic read_all_reset(input string tag);
    rd(3'd0, 32'd0, {tag, "_count"});
    rd(3'd1, 32'd0, {tag, "_ctrl"});
    rd(3'd2, 32'd3, {tag, "_psc"});
    rd(3'd3, 32'd0, {tag, "_period"});
    rd(3'd4, 32'd0, {tag, "_high"});
    rd(3'd5, 32'd0, {tag, "_status"});
    rd(3'd6, 32'd2, {tag, "_filter"});
    rd(3'd7, 32'd0, {tag, "_idx7"});
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; chipSelect = 1'b0; write = 1'b0; read = 1'b0;
    addr = '0; writeData = '0; capture_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_now("rst_readdata", readData, 32'd0);
    expect_now("rst_irq", {31'd0, irq}, 32'd0);
    read_all_reset("rst");

    // 1: basic capture, ignored writes, irq gating, en hold
    wr(3'd2, 32'd0);
    wr(3'd6, 32'd0);
    wr(3'd3, 32'd123);
    wr(3'd7, 32'd55);
    wr(3'd1, 32'd1);
    drive(1'b0, 10);
    period(30, 70);
    period(30, 70);
    rd(3'd3, 32'd100, "t1_period");
    rd(3'd4, 32'd30, "t1_high");
    rd(3'd5, 32'd1, "t1_status");
    rd(3'd7, 32'd0, "t1_idx7");
    expect_now("t1_irq_off", {31'd0, irq}, 32'd0);
    wr(3'd1, 32'd5);
    expect_now("t1_irq_on", {31'd0, irq}, 32'd1);
    wr(3'd5, 32'd1);
    expect_now("t1_irq_cleared", {31'd0, irq}, 32'd0);
    rd(3'd5, 32'd0, "t1_status_clr");
    wr(3'd1, 32'd1);
    @(negedge clk); en = 1'b0;
    wr(3'd2, 32'd9);
    @(negedge clk); en = 1'b1;
    rd(3'd2, 32'd0, "t1_en_hold_psc");

    // 2: prescaler 1 and overrun
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd1);
    wr(3'd1, 32'd1);
    drive(1'b0, 10);
    repeat (3) period(30, 70);
    rd(3'd3, 32'd50, "t2_period");
    rd(3'd4, 32'd15, "t2_high");
    rd(3'd5, 32'd3, "t2_overrun");
    wr(3'd5, 32'd3);
    rd(3'd5, 32'd0, "t2_status_clr");

    // 3: glitch filter
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd6, 32'd4);
    wr(3'd1, 32'd1);
    drive(1'b0, 10);
    repeat (2) begin
      drive(1'b1, 10); drive(1'b0, 3); drive(1'b1, 17); drive(1'b0, 70);
    end
    rd(3'd4, 32'd30, "t3_high_glitch3");
    rd(3'd3, 32'd100, "t3_period_glitch3");
    rd(3'd5, 32'd1, "t3_status_glitch3");
    wr(3'd1, 32'd0);
    wr(3'd5, 32'd7);
    wr(3'd1, 32'd1);
    drive(1'b0, 10);
    drive(1'b1, 10); drive(1'b0, 5); drive(1'b1, 30);
    rd(3'd4, 32'd10, "t3_high_glitch5");
    rd(3'd3, 32'd15, "t3_period_glitch5");
    wr(3'd1, 32'd0);
    wr(3'd5, 32'd7);
    wr(3'd6, 32'd0);
    drive(1'b0, 10);

    // 4: oneshot
    wr(3'd1, 32'd3);
    drive(1'b0, 10);
    period(30, 70);
    period(20, 50);
    period(20, 50);
    rd(3'd3, 32'd100, "t4_period");
    rd(3'd4, 32'd30, "t4_high");
    rd(3'd5, 32'd1, "t4_status");
    rd(3'd1, 32'd2, "t4_ctrl");
    rd(3'd0, 32'd0, "t4_count");
    wr(3'd5, 32'd1);

    // 5: timeout with the counter preloaded near its limit
    wr(3'd1, 32'd1);
    drive(1'b0, 10);
    drive(1'b1, 10);
    @(negedge clk);
    force dut.r_count = 32'hFFFF_FFF0;
    @(posedge clk);
    #1 release dut.r_count;
    drive(1'b1, 40);
    rd(3'd5, 32'd4, "t5_timeout");
    rd(3'd3, 32'd100, "t5_period_kept");
    rd(3'd4, 32'd30, "t5_high_kept");
    rd(3'd0, 32'd0, "t5_count");
    wr(3'd5, 32'd4);
    wr(3'd1, 32'd0);
    drive(1'b0, 5);

    // 6: asynchronous reset mid high phase
    wr(3'd1, 32'd5);
    drive(1'b0, 10);
    period(30, 70);
    drive(1'b1, 10);
    expect_now("t6_irq_before", {31'd0, irq}, 32'd1);
    rd(3'd3, 32'd100, "t6_period_before");
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_now("t6_rst_readdata", readData, 32'd0);
    expect_now("t6_rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    read_all_reset("t6");
    drive(1'b0, 5);
    repeat (5) @(negedge clk);
    done = 1'b1;
  end

endmodule
